key_conditioner: RTL and testbench

Input conditioning stage between the board push-buttons/slide switches and the game/VGA top level. Per key it synchronises the raw active-low KEY pin, debounces it with a per-key state machine, and produces a clean active-high level. It also produces one-cycle press, release and auto-repeat pulses that the top-level control logic consumes directly. Slide switches are passed through a 2-FF synchroniser only.

---
 rtl/key_conditioner.sv | 155 +++++++++++++++
 tb/tb_key_conditioner.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces the board push-buttons and
// produces a clean pressed level plus one-cycle press, release and
// auto-repeat pulses. Slide switches are only passed through two flop stages.
module key_conditioner #(
  parameter int NKEYS           = 3,
  parameter int NSW             = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic [NSW-1:0]   sw_raw,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_repeat,
  output logic [NSW-1:0]   sw_sync
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With auto-repeat disabled RD_LAST is a don't-care; the repeat path is gated off.
  localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic             REPEAT_EN = (REPEAT_DELAY > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    HELD            = 2'd2,
    RELEASE_PENDING = 2'd3
  } key_state_e;

  logic [NKEYS-1:0] key_s1_q;
  logic [NKEYS-1:0] key_s2_q;
  logic [NSW-1:0]   sw_s1_q;
  logic [NSW-1:0]   sw_s2_q;

  // Two-flop synchronisers; keys are inverted so 1 means pressed from here on.
  always_ff @(posedge clock50) begin
    if (reset) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= ~key_n;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign sw_sync = sw_s2_q;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RPT_W-1:0] rcnt_q;
    logic             rdone_q;   // first repeat already issued in this hold
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;

    // Per-key debounce / auto-repeat state machine with registered pulses.
    always_ff @(posedge clock50) begin
      if (reset) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        rcnt_q    <= '0;
        rdone_q   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (key_s2_q[k]) begin
              state_q <= PRESS_PENDING;
              cnt_q   <= '0;
            end
          end
          PRESS_PENDING: begin
            if (!key_s2_q[k]) begin
              state_q <= RELEASED;
            end else if (cnt_q == DB_LAST) begin
              state_q <= HELD;
              press_q <= 1'b1;
              level_q <= 1'b1;
              rcnt_q  <= '0;
              rdone_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          HELD: begin
            if (!key_s2_q[k]) begin
              state_q <= RELEASE_PENDING;
              cnt_q   <= '0;
              rcnt_q  <= '0;
              rdone_q <= 1'b0;
            end else if (REPEAT_EN) begin
              // Counter reloads to 0 on each tick, so it never wraps.
              if (rcnt_q == (rdone_q ? RP_LAST : RD_LAST)) begin
                repeat_q <= 1'b1;
                rcnt_q   <= '0;
                rdone_q  <= 1'b1;
              end else begin
                rcnt_q <= rcnt_q + RPT_W'(1);
              end
            end else begin
              rcnt_q <= '0;
            end
          end
          RELEASE_PENDING: begin
            if (key_s2_q[k]) begin
              state_q <= HELD;
              rcnt_q  <= '0;
              rdone_q <= 1'b0;
            end else if (cnt_q == DB_LAST) begin
              state_q   <= RELEASED;
              release_q <= 1'b1;
              level_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            rdone_q <= 1'b0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_repeat[k]  = repeat_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with a run-length reference model.
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int NS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          clock50 = 1'b0;
  logic          reset   = 1'b1;
  logic [NK-1:0] key_n   = 3'b000;
  logic [NS-1:0] sw_raw  = 2'b11;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;
  logic [NS-1:0] sw_sync;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .NKEYS(NK), .NSW(NS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock50(clock50), .reset(reset), .key_n(key_n), .sw_raw(sw_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .sw_sync(sw_sync)
  );

  always #5 clock50 = ~clock50;

  // Reference model: a key flips its accepted level once the synchronised
  // input has disagreed with it for DB+1 consecutive samples; repeat ticks
  // are counted as cycles spent stably held since the press (or since a
  // rejected release glitch).
  logic [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_rep;
  logic [NS-1:0] m_sw1, m_sw2;
  int  run [NK];
  int  rt  [NK];
  bit  nf  [NK];

  always @(posedge clock50) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
      m_sw1 = '0; m_sw2 = '0;
      for (int k = 0; k < NK; k++) begin run[k] = 0; rt[k] = 0; nf[k] = 0; end
    end else begin
      for (int k = 0; k < NK; k++) begin
        m_press[k] = 1'b0; m_rel[k] = 1'b0; m_rep[k] = 1'b0;
        if (!m_lvl[k]) begin
          if (m_s2[k]) begin
            run[k]++;
            if (run[k] == DB + 1) begin
              m_lvl[k] = 1'b1; m_press[k] = 1'b1; run[k] = 0; rt[k] = 0; nf[k] = 0;
            end
          end else run[k] = 0;
        end else begin
          if (!m_s2[k]) begin
            run[k]++; rt[k] = 0;
            if (run[k] == DB + 1) begin
              m_lvl[k] = 1'b0; m_rel[k] = 1'b1; run[k] = 0;
            end
          end else if (run[k] > 0) begin
            run[k] = 0; rt[k] = 0; nf[k] = 0;
          end else begin
            rt[k]++;
            if (RD > 0 && rt[k] == (nf[k] ? RP : RD)) begin
              m_rep[k] = 1'b1; rt[k] = 0; nf[k] = 1;
            end
          end
        end
      end
      m_s2 = m_s1; m_s1 = ~key_n; m_sw2 = m_sw1; m_sw1 = sw_raw;
    end
  end

  function automatic logic [13:0] dut_vec();
    return {key_level, key_press, key_release, key_repeat, sw_sync};
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_lvl, m_press, m_rel, m_rep, m_sw2};
  endfunction

  task automatic tick();
    @(posedge clock50);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_n = 3'b000; sw_raw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec() !== 14'h0) begin
        errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 14'h0);
      end
    end
    reset = 1'b0; key_n = 3'b111; sw_raw = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_switch();
    logic [NS-1:0] pat [2];
    logic [NS-1:0] prev;
    pat[0] = 2'b01; pat[1] = 2'b10; prev = 2'b00;
    for (int p = 0; p < 2; p++) begin
      sw_raw = pat[p];
      tick();
      checks++;
      if (sw_sync !== prev) begin
        errors++; $display("FAIL sw_one_edge got=%b exp=%b", sw_sync, prev);
      end
      tick();
      checks++;
      if (sw_sync !== pat[p]) begin
        errors++; $display("FAIL sw_two_edges got=%b exp=%b", sw_sync, pat[p]);
      end
      prev = pat[p];
    end
    sw_raw = 2'b00;
    tick(); tick();
  endtask

  task automatic test_press();
    key_n = 3'b110;
    for (int n = 1; n <= 9; n++) begin
      tick();
      checks++;
      if (key_press !== ((n == 7) ? 3'b001 : 3'b000) ||
          key_level !== ((n >= 7) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL press_k0 edge=%0d got press=%b level=%b exp press=%b level=%b",
                 n, key_press, key_level, (n == 7) ? 3'b001 : 3'b000, (n >= 7) ? 3'b001 : 3'b000);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL press_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_bounce();
    key_n[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) key_n[1] = 1'b1;
      tick();
      checks++;
      if (key_press[1] !== 1'b0 || key_level[1] !== 1'b0) begin
        errors++; $display("FAIL bounce_glitch got press=%b level=%b exp 0 0", key_press[1], key_level[1]);
      end
    end
    key_n[1] = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      checks++;
      if (key_press[1] !== (n == 7) || key_level[1] !== (n >= 7)) begin
        errors++;
        $display("FAIL bounce_press edge=%0d got press=%b level=%b exp press=%b level=%b",
                 n, key_press[1], key_level[1], n == 7, n >= 7);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL bounce_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 10; i++) begin
      key_n[0] = (i < 2) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (key_release[0] !== 1'b0 || key_level[0] !== 1'b1) begin
        errors++; $display("FAIL release_glitch got rel=%b level=%b exp 0 1", key_release[0], key_level[0]);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL release_glitch_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    key_n[0] = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      checks++;
      if (key_release[0] !== (n == 7) || key_level[0] !== (n < 7)) begin
        errors++;
        $display("FAIL release_k0 edge=%0d got rel=%b level=%b exp rel=%b level=%b",
                 n, key_release[0], key_level[0], n == 7, n < 7);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL release_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_repeat();
    bit seen;
    bit exp_rep;
    seen = 1'b0;
    key_n[2] = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (key_press[2] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL repeat_press_timeout got press=0 exp press within 20 edges");
    end
    for (int j = 1; j <= 40; j++) begin
      tick();
      exp_rep = (j >= RD) && (((j - RD) % RP) == 0);
      checks++;
      if (key_repeat[2] !== exp_rep) begin
        errors++; $display("FAIL repeat_k2 offset=%0d got=%b exp=%b", j, key_repeat[2], exp_rep);
      end
      checks++;
      if ((key_press & key_repeat) !== 3'b000) begin
        errors++; $display("FAIL repeat_overlap got=%b exp=000", key_press & key_repeat);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL repeat_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    key_n = 3'b111;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_back_to_back();
    key_n = 3'b100;
    for (int n = 1; n <= 7; n++) begin
      tick();
      checks++;
      if (key_press[1:0] !== ((n == 7) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL simul_press edge=%0d got=%b exp=%b", n, key_press[1:0], (n == 7) ? 2'b11 : 2'b00);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== 14'h0) begin
      errors++; $display("FAIL simul_reset got=%h exp=%h", dut_vec(), 14'h0);
    end
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      checks++;
      if (key_press[1:0] !== ((n == 7) ? 2'b11 : 2'b00) || key_release !== 3'b000) begin
        errors++;
        $display("FAIL simul_repress edge=%0d got press=%b rel=%b exp press=%b rel=000",
                 n, key_press[1:0], key_release, (n == 7) ? 2'b11 : 2'b00);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL simul_model got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    int dur [NK];
    for (int k = 0; k < NK; k++) dur[k] = $urandom_range(1, 14);
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++) begin
        dur[k]--;
        if (dur[k] <= 0) begin
          key_n[k] = ~key_n[k];
          dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
        end
      end
      if ($urandom_range(0, 9) == 0) sw_raw = NS'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_model cycle=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_press();
    test_bounce();
    test_release();
    test_repeat();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
